// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweep checker: state encoding and
// reference truth tables for the common 2-input functions.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_t;

  // Bit i is the expected output when the stimulus vector equals i.
  localparam logic [3:0] TT_IMPL = 4'b1011;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable 4-bit down-counter with a zero flag.
// It paces the settle interval between driving a vector and sampling it.
module tt_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/tt_sweep_checker.sv
// Drives every input vector onto a boolean function under test and checks both copies
// against EXP_TT. Optional mism_map output: define TT_SWEEP_MISMATCH_MAP_EN.
module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter int                       N_IN   = 2,
  parameter int                       SETTLE = 1,
  parameter logic [(1<<N_IN)-1:0]     EXP_TT = TT_IMPL
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [N_IN-1:0]      vec_out,
  input  logic                 dut_a,
  input  logic                 dut_b,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_cnt,
  output logic [N_IN-1:0]      first_err_idx,
  output logic                 first_err_vld
`ifdef TT_SWEEP_MISMATCH_MAP_EN
  ,
  output logic [(1<<N_IN)-1:0] mism_map
`endif
);

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  sweep_state_t        state_q, state_d;
  logic [N_IN-1:0]     vec_q, vec_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [N_IN:0]       err_cnt_q, err_cnt_d;
  logic [N_IN-1:0]     fidx_q, fidx_d;
  logic                fvld_q, fvld_d;
  logic [(1<<N_IN)-1:0] map_q, map_d;
  logic                tmr_load, tmr_dec, tmr_zero;
  logic                fail;

  tt_settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (SETTLE_CNT),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_cnt_d = err_cnt_q;
    fidx_d    = fidx_q;
    fvld_d    = fvld_q;
    map_d     = map_q;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    fail      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SETTLE;
          vec_d     = '0;
          busy_d    = 1'b1;
          pass_d    = 1'b0;
          err_cnt_d = '0;
          fidx_d    = '0;
          fvld_d    = 1'b0;
          map_d     = '0;
          tmr_load  = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          state_d = ST_SAMPLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_SAMPLE: begin
        // Outputs are only looked at here, so settling glitches never count.
        fail = (dut_a != EXP_TT[vec_q]) | (dut_b != EXP_TT[vec_q]);
        if (fail) begin
          err_cnt_d    = err_cnt_q + (N_IN+1)'(1);
          map_d[vec_q] = 1'b1;
          if (!fvld_q) begin
            fidx_d = vec_q;
            fvld_d = 1'b1;
          end
        end
        if (&vec_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == '0);
        end else begin
          state_d  = ST_SETTLE;
          vec_d    = vec_q + N_IN'(1);
          tmr_load = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      vec_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_cnt_q <= '0;
      fidx_q    <= '0;
      fvld_q    <= 1'b0;
      map_q     <= '0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_cnt_q <= err_cnt_d;
      fidx_q    <= fidx_d;
      fvld_q    <= fvld_d;
      map_q     <= map_d;
    end
  end

  assign vec_out       = vec_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = fidx_q;
  assign first_err_vld = fvld_q;

`ifdef TT_SWEEP_MISMATCH_MAP_EN
  assign mism_map = map_q;
`else
  logic unused_map;
  assign unused_map = ^map_q;
`endif

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench for tt_sweep_checker: default implication instance plus a
// one-input, zero-settle instance checking ~y.
module tb_tt_sweep_checker;

  typedef struct packed {
    logic       pass;
    logic [2:0] err;
    logic [1:0] fidx;
    logic       fvld;
    logic [3:0] map;
    int         done_edge;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start, start2;
  logic [1:0] vec_out;
  logic       dut_a, dut_b;
  logic       busy, done, pass;
  logic [2:0] err_cnt;
  logic [1:0] first_err_idx;
  logic       first_err_vld;
  logic       mode_a, mode_b;

  logic [0:0] vec_out2;
  logic       dut2_y;
  logic       busy2, done2, pass2;
  logic [1:0] err_cnt2;
  logic [0:0] fidx2;
  logic       fvld2;
`ifdef TT_SWEEP_MISMATCH_MAP_EN
  logic [3:0] mism_map;
  logic [1:0] mism_map2;
`endif

  int   n_chk = 0;
  int   n_fail = 0;
  int   edge_n = 0;
  exp_t sb[$];
  exp_t sb2[$];

  tt_sweep_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_out(vec_out),
    .dut_a(dut_a), .dut_b(dut_b), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_idx(first_err_idx), .first_err_vld(first_err_vld)
`ifdef TT_SWEEP_MISMATCH_MAP_EN
    , .mism_map(mism_map)
`endif
  );

  tt_sweep_checker #(.N_IN(1), .SETTLE(0), .EXP_TT(2'b01)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .vec_out(vec_out2),
    .dut_a(dut2_y), .dut_b(dut2_y), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err_cnt2), .first_err_idx(fidx2), .first_err_vld(fvld2)
`ifdef TT_SWEEP_MISMATCH_MAP_EN
    , .mism_map(mism_map2)
`endif
  );

  // Function under test: x = vec_out[1], y = vec_out[0].
  always_comb begin
    dut_a  = mode_a ? (vec_out[1] | vec_out[0]) : (~vec_out[1] | vec_out[0]);
    dut_b  = mode_b ? 1'b1 : (~vec_out[1] | vec_out[0]);
    dut2_y = ~vec_out2[0];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Monitors: pop expected results whenever a done pulse is seen.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_edge", edge_n, e.done_edge);
        chk("pass", {31'd0, pass}, {31'd0, e.pass});
        chk("err_cnt", {29'd0, err_cnt}, {29'd0, e.err});
        chk("first_err_idx", {30'd0, first_err_idx}, {30'd0, e.fidx});
        chk("first_err_vld", {31'd0, first_err_vld}, {31'd0, e.fvld});
`ifdef TT_SWEEP_MISMATCH_MAP_EN
        chk("mism_map", {28'd0, mism_map}, {28'd0, e.map});
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (sb2.size() == 0) begin
        chk("unexpected_done2", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb2.pop_front();
        chk("done_edge2", edge_n, e.done_edge);
        chk("pass2", {31'd0, pass2}, {31'd0, e.pass});
        chk("err_cnt2", {30'd0, err_cnt2}, {29'd0, e.err});
      end
    end
  end

  task automatic wait_drain(input bit which, input int bound);
    int t = 0;
    while (((which ? sb2.size() : sb.size()) != 0) && (t < bound)) begin
      @(negedge clk);
      t++;
    end
    chk(which ? "drain2_outstanding" : "drain_outstanding",
        which ? sb2.size() : sb.size(), 32'd0);
    if (which) sb2.delete(); else sb.delete();
  endtask

  function automatic exp_t mk(input logic p, input logic [2:0] er, input logic [1:0] fi,
                              input logic fv, input logic [3:0] mp, input int de);
    exp_t e;
    e.pass = p; e.err = er; e.fidx = fi; e.fvld = fv; e.map = mp; e.done_edge = de;
    return e;
  endfunction

  // Called at a negedge; start is sampled at the following edge k.
  task automatic sweep(input bit ma, input bit mb, input exp_t e);
    mode_a = ma;
    mode_b = mb;
    start  = 1'b1;
    e.done_edge = edge_n + 1 + 12;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 12; j++) begin
      chk("vec_out_seq", {30'd0, vec_out}, j / 3);
      chk("busy_in_sweep", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    @(negedge clk);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    chk("err_cnt_held", {29'd0, err_cnt}, {29'd0, e.err});
    chk("vec_out_held", {30'd0, vec_out}, 32'd3);
    wait_drain(1'b0, 5);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; mode_a = 1'b0; mode_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vec_out", {30'd0, vec_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_err_cnt", {29'd0, err_cnt}, 32'd0);
    chk("rst_first_err", {29'd0, first_err_idx, first_err_vld}, 32'd0);
    chk("rst_busy2", {31'd0, busy2}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Both copies correct, then gate copy x|y, then dut_b stuck at 1.
    sweep(1'b0, 1'b0, mk(1'b1, 3'd0, 2'd0, 1'b0, 4'b0000, 0));
    sweep(1'b1, 1'b0, mk(1'b0, 3'd2, 2'd0, 1'b1, 4'b0101, 0));
    sweep(1'b0, 1'b1, mk(1'b0, 3'd1, 2'd2, 1'b1, 4'b0100, 0));

    // start held high: relaunch only after DONE, results cleared on relaunch.
    mode_a = 1'b1; mode_b = 1'b0;
    start = 1'b1;
    k = edge_n + 1;
    sb.push_back(mk(1'b0, 3'd2, 2'd0, 1'b1, 4'b0101, k + 12));
    sb.push_back(mk(1'b0, 3'd2, 2'd0, 1'b1, 4'b0101, k + 26));
    repeat (13) @(negedge clk);
    chk("hold_busy_k12", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("hold_busy_k13", {31'd0, busy}, 32'd0);
    chk("hold_err_k13", {29'd0, err_cnt}, 32'd2);
    @(negedge clk);
    chk("relaunch_busy", {31'd0, busy}, 32'd1);
    chk("relaunch_err_clr", {29'd0, err_cnt}, 32'd0);
    chk("relaunch_fvld_clr", {31'd0, first_err_vld}, 32'd0);
    chk("relaunch_vec", {30'd0, vec_out}, 32'd0);
    start = 1'b0;
    wait_drain(1'b0, 30);
    repeat (3) @(negedge clk);

    // Reset at edge k+5 mid-sweep, after one error was already counted.
    mode_a = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_err", {29'd0, err_cnt}, 32'd1);
    @(negedge clk);
    chk("pre_rst_vec", {30'd0, vec_out}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_vec", {30'd0, vec_out}, 32'd0);
    chk("midrst_err", {29'd0, err_cnt}, 32'd0);
    chk("midrst_fvld", {31'd0, first_err_vld}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

    // One input, zero settle, expecting ~y.
    start2 = 1'b1;
    sb2.push_back(mk(1'b1, 3'd0, 2'd0, 1'b0, 4'd0, edge_n + 1 + 4));
    @(negedge clk);
    start2 = 1'b0;
    wait_drain(1'b1, 20);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
